// File: rtl/div_share_arb.sv
// Round-robin arbiter that time-shares one fixed-point divider among NREQ requesters.
// Define DIV_TIMEOUT_EN to add a watchdog that aborts a divide the divider never finishes.
module div_share_arb #(
   parameter int NREQ        = 4,
   parameter int WIDTH       = 32,
   parameter int FBITS       = 4,
   parameter int IDW         = $clog2(NREQ),
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] a_in,
   input  logic [NREQ*WIDTH-1:0] b_in,
   output logic [NREQ-1:0]       req_ack,
   output logic                  rsp_vld,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_val,
   output logic                  rsp_valid,
   output logic                  rsp_dbz,
   output logic                  rsp_tmo,
   output logic                  busy,
   output logic                  div_start,
   output logic [WIDTH-1:0]      div_a,
   output logic [WIDTH-1:0]      div_b,
   input  logic                  div_done,
   input  logic [WIDTH-1:0]      div_val,
   input  logic                  div_valid,
   input  logic                  div_dbz
);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

   localparam int SW = IDW + 1;

   // An out-of-range configuration never grants, so a bad instance hangs visibly
   // instead of returning quietly wrong quotients.
   localparam logic CFG_BAD = (FBITS >= WIDTH) || (FBITS < 0) || (IDW < $clog2(NREQ)) ||
                              (TIMEOUT_CYC < 1) || (TIMEOUT_CYC > 255);

   state_t           state, state_nx;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   owner;
   logic             grant_hit;
   logic [IDW-1:0]   grant_id;
   logic [IDW-1:0]   grant_ptr;
   logic [WIDTH-1:0] grant_a;
   logic [WIDTH-1:0] grant_b;
   logic             tmo_hit;
   logic             launch_ev;
   logic             finish_ev;

   // Scan starting at rr_ptr and wrapping modulo NREQ; the first set request wins.
   always_comb begin
      logic [SW-1:0]  sum;
      logic [IDW-1:0] idx;
      grant_hit = 1'b0;
      grant_id  = '0;
      grant_ptr = '0;
      grant_a   = '0;
      grant_b   = '0;
      sum       = '0;
      idx       = '0;
      for (int i = 0; i < NREQ; i++) begin
         sum = {1'b0, rr_ptr} + SW'(i);
         if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
         idx = sum[IDW-1:0];
         if (!grant_hit && req[idx]) begin
            grant_hit = 1'b1;
            grant_id  = idx;
            grant_ptr = (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
            grant_a   = a_in[idx*WIDTH +: WIDTH];
            grant_b   = b_in[idx*WIDTH +: WIDTH];
         end
      end
   end

   assign launch_ev = (state == IDLE) && grant_hit && !CFG_BAD;
   assign finish_ev = (state == WAIT) && (div_done || tmo_hit);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (launch_ev) state_nx = LAUNCH;
         LAUNCH:  state_nx = WAIT;
         WAIT:    if (finish_ev) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

`ifdef DIV_TIMEOUT_EN
   logic [7:0] tmo_cnt;

   // Counts WAIT cycles; done in the same cycle as the limit still wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                tmo_cnt <= '0;
      else if (state != WAIT)  tmo_cnt <= '0;
      else                     tmo_cnt <= tmo_cnt + 8'd1;
   end

   assign tmo_hit = (state == WAIT) && !div_done && (tmo_cnt == 8'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           rsp_tmo <= 1'b0;
      else if (finish_ev) rsp_tmo <= tmo_hit;
   end
`else
   assign tmo_hit = 1'b0;
   assign rsp_tmo = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         req_ack   <= '0;
         div_start <= 1'b0;
         div_a     <= '0;
         div_b     <= '0;
         busy      <= 1'b0;
         rsp_vld   <= 1'b0;
         rsp_id    <= '0;
         rsp_val   <= '0;
         rsp_valid <= 1'b0;
         rsp_dbz   <= 1'b0;
      end else begin
         state     <= state_nx;
         busy      <= (state_nx != IDLE);
         req_ack   <= '0;
         div_start <= 1'b0;
         rsp_vld   <= 1'b0;
         if (launch_ev) begin
            div_a     <= grant_a;
            div_b     <= grant_b;
            owner     <= grant_id;
            rr_ptr    <= grant_ptr;
            req_ack   <= NREQ'(1) << grant_id;
            div_start <= 1'b1;
         end
         if (finish_ev) begin
            rsp_vld   <= 1'b1;
            rsp_id    <= owner;
            rsp_val   <= div_done ? div_val : '0;
            rsp_valid <= div_done & div_valid;
            rsp_dbz   <= div_done & div_dbz;
         end
      end
   end

endmodule

// File: tb/tb_div_share_arb.sv
// Directed scoreboard bench for div_share_arb with a behavioural fixed-point divider.
// Covers DIV_TIMEOUT_EN when that macro is defined for the build.
module tb_div_share_arb;

   localparam int NREQ = 4;
   localparam int WIDTH = 32;
   localparam int DIV_LAT = 6;

   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] val;
      logic        valid;
      logic        dbz;
      logic        tmo;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] a_in;
   logic [NREQ*WIDTH-1:0] b_in;
   logic [NREQ-1:0]       req_ack;
   logic                  rsp_vld;
   logic [1:0]            rsp_id;
   logic [WIDTH-1:0]      rsp_val;
   logic                  rsp_valid;
   logic                  rsp_dbz;
   logic                  rsp_tmo;
   logic                  busy;
   logic                  div_start;
   logic [WIDTH-1:0]      div_a;
   logic [WIDTH-1:0]      div_b;
   logic                  div_done;
   logic [WIDTH-1:0]      div_val;
   logic                  div_valid;
   logic                  div_dbz;

   logic                  hang;
   logic [7:0]            mdlCnt;
   logic [31:0]           mdlA, mdlB;
   logic [63:0]           mdlQ;

   int   errors = 0;
   int   checks = 0;
   int   rspSeen = 0;
   int   ackCount [NREQ];
   exp_t sbq [$];

   div_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .FBITS(4), .IDW(2), .TIMEOUT_CYC(64)) dut (
      .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
      .req_ack(req_ack), .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_val(rsp_val),
      .rsp_valid(rsp_valid), .rsp_dbz(rsp_dbz), .rsp_tmo(rsp_tmo), .busy(busy),
      .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_done(div_done),
      .div_val(div_val), .div_valid(div_valid), .div_dbz(div_dbz)
   );

   always #5 clk = ~clk;

   // Divider stand-in: fixed latency after start, Q4 quotient, hang disables done.
   assign mdlQ = ({32'd0, mdlA} << 4) / ((mdlB == 32'd0) ? 64'd1 : {32'd0, mdlB});

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mdlCnt    <= '0;
         mdlA      <= '0;
         mdlB      <= '0;
         div_done  <= 1'b0;
         div_val   <= '0;
         div_valid <= 1'b0;
         div_dbz   <= 1'b0;
      end else begin
         div_done <= 1'b0;
         if (div_start) begin
            mdlCnt <= 8'(DIV_LAT);
            mdlA   <= div_a;
            mdlB   <= div_b;
         end else if (mdlCnt != 8'd0) begin
            mdlCnt <= mdlCnt - 8'd1;
            if (mdlCnt == 8'd1 && !hang) begin
               div_done  <= 1'b1;
               div_val   <= (mdlB == 32'd0) ? 32'd0 : mdlQ[31:0];
               div_valid <= (mdlB != 32'd0) && (mdlQ[63:32] == 32'd0);
               div_dbz   <= (mdlB == 32'd0);
            end
         end
      end
   end

   // Records one comparison result and reports observed/expected on failure.
   task automatic checkOutput(input string tag, input logic ok, input logic [63:0] obs,
                              input logic [63:0] exp);
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mkExp(input logic [1:0] id, input logic [31:0] val,
                                  input logic valid, input logic dbz, input logic tmo);
      exp_t e;
      e.id = id; e.val = val; e.valid = valid; e.dbz = dbz; e.tmo = tmo;
      return e;
   endfunction

   task automatic applyStimulus(input logic [1:0] id, input logic [31:0] a, input logic [31:0] b);
      a_in[id*WIDTH +: WIDTH] = a;
      b_in[id*WIDTH +: WIDTH] = b;
   endtask

   // Waits for the ack of one requester, then drops its request; reports busy-low gaps.
   task automatic waitAck(input logic [1:0] id, output int gaps, output int lat);
      gaps = 0;
      lat  = 0;
      do begin
         @(negedge clk);
         lat++;
         if (busy === 1'b0 && req_ack[id] !== 1'b1) gaps++;
      end while (req_ack[id] !== 1'b1 && lat < 300);
      checkOutput($sformatf("ack%0d_seen", id), req_ack[id] === 1'b1, req_ack[id], 1'b1);
      req[id] = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain", sbq.size() === 0, sbq.size(), 0);
      @(negedge clk);
   endtask

   // Response monitor: pops the scoreboard on every rsp_vld.
   always @(negedge clk) begin
      exp_t e;
      if (req_ack !== 4'b0000) begin
         checkOutput("ack_onehot", $onehot(req_ack) === 1, $onehot(req_ack), 1);
         checkOutput("start_with_ack", div_start === 1'b1, div_start, 1'b1);
         for (int i = 0; i < NREQ; i++) if (req_ack[i[1:0]] === 1'b1) ackCount[i]++;
      end
      if (rsp_vld === 1'b1) begin
         rspSeen++;
         checkOutput("rsp_busy", busy === 1'b1, busy, 1'b1);
         if (sbq.size() == 0) begin
            checkOutput("rsp_unexpected", rsp_vld === 1'b0, rsp_vld, 1'b0);
         end else begin
            e = sbq.pop_front();
            checkOutput("rsp_id", rsp_id === e.id, rsp_id, e.id);
            checkOutput("rsp_val", rsp_val === e.val, rsp_val, e.val);
            checkOutput("rsp_valid", rsp_valid === e.valid, rsp_valid, e.valid);
            checkOutput("rsp_dbz", rsp_dbz === e.dbz, rsp_dbz, e.dbz);
            checkOutput("rsp_tmo", rsp_tmo === e.tmo, rsp_tmo, e.tmo);
         end
      end
   end

   initial begin
      int gaps, lat, snap0, snap1, snap2, snap3, rspBefore;
      for (int i = 0; i < NREQ; i++) ackCount[i] = 0;
      rst  = 1'b0;
      req  = '0;
      a_in = '0;
      b_in = '0;
      hang = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", busy === 1'b0, busy, 1'b0);
      checkOutput("rst_req_ack", req_ack === 4'b0000, req_ack, 4'b0000);
      checkOutput("rst_rsp_vld", rsp_vld === 1'b0, rsp_vld, 1'b0);
      checkOutput("rst_div_start", div_start === 1'b0, div_start, 1'b0);
      checkOutput("rst_div_a", div_a === 32'd0, div_a, 32'd0);
      checkOutput("rst_rsp_val", rsp_val === 32'd0, rsp_val, 32'd0);
      checkOutput("rst_rsp_tmo", rsp_tmo === 1'b0, rsp_tmo, 1'b0);
      rst = 1'b1;
      @(negedge clk);

      // Single request: ack exactly one cycle after req is seen.
      applyStimulus(2'd0, 32'hA0, 32'h20);
      sbq.push_back(mkExp(2'd0, 32'h50, 1'b1, 1'b0, 1'b0));
      req[0] = 1'b1;
      waitAck(2'd0, gaps, lat);
      checkOutput("c1_ack_latency", lat === 1, lat, 1);
      checkOutput("c1_req_ack", req_ack === 4'b0001, req_ack, 4'b0001);
      checkOutput("c1_div_start", div_start === 1'b1, div_start, 1'b1);
      checkOutput("c1_div_a", div_a === 32'hA0, div_a, 32'hA0);
      checkOutput("c1_div_b", div_b === 32'h20, div_b, 32'h20);
      checkOutput("c1_busy", busy === 1'b1, busy, 1'b1);
      @(negedge clk);
      checkOutput("c1_start_pulse", div_start === 1'b0, div_start, 1'b0);
      checkOutput("c1_ack_pulse", req_ack === 4'b0000, req_ack, 4'b0000);
      drain();
      checkOutput("c1_rsp_hold", rsp_val === 32'h50, rsp_val, 32'h50);
      checkOutput("c1_vld_pulse", rsp_vld === 1'b0, rsp_vld, 1'b0);

      // Divide by zero from requester 2, then a normal one from requester 3.
      applyStimulus(2'd2, 32'h30, 32'h0);
      sbq.push_back(mkExp(2'd2, 32'h0, 1'b0, 1'b1, 1'b0));
      req[2] = 1'b1;
      waitAck(2'd2, gaps, lat);
      checkOutput("c4_div_b", div_b === 32'h0, div_b, 32'h0);
      drain();
      checkOutput("c4_dbz_hold", rsp_dbz === 1'b1, rsp_dbz, 1'b1);
      applyStimulus(2'd3, 32'h64, 32'h08);
      sbq.push_back(mkExp(2'd3, 32'hC8, 1'b1, 1'b0, 1'b0));
      req[3] = 1'b1;
      waitAck(2'd3, gaps, lat);
      drain();

      // All four held with pointer at 0: served 0,1,2,3, one idle cycle between grants.
      snap0 = ackCount[0]; snap1 = ackCount[1]; snap2 = ackCount[2]; snap3 = ackCount[3];
      for (int i = 0; i < NREQ; i++) begin
         applyStimulus(i[1:0], 32'h100 + 32'(i) * 32'h40, 32'h10);
         sbq.push_back(mkExp(i[1:0], 32'h100 + 32'(i) * 32'h40, 1'b1, 1'b0, 1'b0));
      end
      req = 4'b1111;
      for (int i = 0; i < NREQ; i++) begin
         waitAck(i[1:0], gaps, lat);
         if (i > 0) checkOutput($sformatf("c2_gap%0d", i), gaps === 1, gaps, 1);
      end
      drain();
      checkOutput("c2_acks0", (ackCount[0] - snap0) === 1, ackCount[0] - snap0, 1);
      checkOutput("c2_acks1", (ackCount[1] - snap1) === 1, ackCount[1] - snap1, 1);
      checkOutput("c2_acks2", (ackCount[2] - snap2) === 1, ackCount[2] - snap2, 1);
      checkOutput("c2_acks3", (ackCount[3] - snap3) === 1, ackCount[3] - snap3, 1);

      // Requesters 0 and 3, then 1 and 3: pointer wrapped to 0 after serving 3.
      applyStimulus(2'd0, 32'h40, 32'h20);
      applyStimulus(2'd3, 32'h90, 32'h30);
      sbq.push_back(mkExp(2'd0, 32'h20, 1'b1, 1'b0, 1'b0));
      sbq.push_back(mkExp(2'd3, 32'h30, 1'b1, 1'b0, 1'b0));
      req = 4'b1001;
      waitAck(2'd0, gaps, lat);
      waitAck(2'd3, gaps, lat);
      drain();
      applyStimulus(2'd1, 32'h70, 32'h10);
      applyStimulus(2'd3, 32'h20, 32'h40);
      sbq.push_back(mkExp(2'd1, 32'h70, 1'b1, 1'b0, 1'b0));
      sbq.push_back(mkExp(2'd3, 32'h08, 1'b1, 1'b0, 1'b0));
      req = 4'b1010;
      waitAck(2'd1, gaps, lat);
      waitAck(2'd3, gaps, lat);
      drain();

      // Reset while waiting on the divider: everything clears, nothing is returned.
      applyStimulus(2'd1, 32'h50, 32'h10);
      req[1] = 1'b1;
      waitAck(2'd1, gaps, lat);
      @(negedge clk);
      rspBefore = rspSeen;
      rst = 1'b0;
      #1;
      checkOutput("c5_busy", busy === 1'b0, busy, 1'b0);
      checkOutput("c5_div_a", div_a === 32'd0, div_a, 32'd0);
      checkOutput("c5_div_start", div_start === 1'b0, div_start, 1'b0);
      checkOutput("c5_rsp_vld", rsp_vld === 1'b0, rsp_vld, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (12) @(negedge clk);
      checkOutput("c5_no_rsp", (rspSeen - rspBefore) === 0, rspSeen - rspBefore, 0);
      applyStimulus(2'd1, 32'h90, 32'h18);
      sbq.push_back(mkExp(2'd1, 32'h60, 1'b1, 1'b0, 1'b0));
      req[1] = 1'b1;
      waitAck(2'd1, gaps, lat);
      drain();

      // Divider that never finishes.
      hang = 1'b1;
      applyStimulus(2'd0, 32'h10, 32'h10);
`ifdef DIV_TIMEOUT_EN
      sbq.push_back(mkExp(2'd0, 32'h0, 1'b0, 1'b0, 1'b1));
`endif
      req[0] = 1'b1;
      rspBefore = rspSeen;
      waitAck(2'd0, gaps, lat);
`ifdef DIV_TIMEOUT_EN
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (rsp_vld !== 1'b1 && lat < 200);
      checkOutput("c6_tmo_latency", lat === 65, lat, 65);
      drain();
      checkOutput("c6_tmo_hold", rsp_tmo === 1'b1, rsp_tmo, 1'b1);
`else
      repeat (100) @(negedge clk);
      checkOutput("c6_busy_stuck", busy === 1'b1, busy, 1'b1);
      checkOutput("c6_no_rsp", (rspSeen - rspBefore) === 0, rspSeen - rspBefore, 0);
`endif
      rst = 1'b0;
      repeat (2) @(negedge clk);
      hang = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("end_busy", busy === 1'b0, busy, 1'b0);
      checkOutput("sb_empty", sbq.size() === 0, sbq.size(), 0);

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
